fft_twiddle_sequencer: RTL
==========================

Name: fft_twiddle_sequencer

Overview:
- Produces the ordered stream of radix-2 DIT twiddle factors W_N^k = cos(2πk/N) − i·sin(2πk/N), one per butterfly, across all log2(N) stages.
- Drives the twiddle operand of the downstream complex multiplier, Q1.15 packed {re, im}.
- Uses a quarter-wave cosine ROM plus symmetry folding.
- Uses a valid/ready handshake so the FFT datapath can stall it.

Parameters:
- N, 256: FFT points; power of two, 16..1024.
- F, 15: fractional bits of twiddle output; word is 16-bit signed.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  pulse that begins a full sequence; ignored while o_busy=1.
- i_ready  in  1  downstream accepts o_twiddle this cycle.
- o_valid  out  1  o_twiddle/o_stage/o_k hold a valid twiddle.
- o_twiddle  out  [0:1][15:0] signed  {re, im} Q1.15.
- o_stage  out  $clog2($clog2(N))  stage s of the current twiddle.
- o_k  out  $clog2(N)−1  exponent k of the current twiddle.
- o_busy  out  1  sequence in progress (RUN or DRAIN).
- o_done  out  1  one-cycle pulse after the last twiddle handshake.

Behaviour:
- Reset (async assert, sync deassert by system): all outputs 0, FSM=IDLE, counters=0.
- Reset mid-sequence aborts immediately; no o_done is produced.
- ROM: N/4+1 entries. rom[m] = round(cos(2πm/N)·2^F), clamped to 32767; it is computed by an elaboration-time function.
- Counters: stage s = 0..log2(N)−1, butterfly j = 0..N/2−1, j fastest.
- Exponent: k = (j mod 2^s)·(N >> (s+1)).
- Folding for k ≤ N/4: re = rom[k], im = −rom[N/4−k].
- Folding for N/4 < k < N/2: re = −rom[N/2−k], im = −rom[k−N/4].
- Negation is plain two's complement. Input magnitude ≤ 32767, so there is no overflow.
- Pipeline: P0 is address/fold computation, registered. P1 is ROM read, sign apply and output register.
- Stall rule: the pipeline advances only when !o_valid || i_ready.
- While o_valid && !i_ready, all outputs hold stable.
- A handshake is o_valid && i_ready.
- FSM IDLE → RUN on i_start. First o_valid appears 2 cycles after the i_start edge.
- RUN → DRAIN once the last (s = log2N−1, j = N/2−1) entry has been issued into P0.
- DRAIN → DONE when the last entry handshakes.
- DONE lasts one cycle with o_done=1, then returns to IDLE.
- Total handshakes per sequence: (N/2)·log2(N).
- With i_ready held at 1, one twiddle is produced per cycle with no bubbles, including across stage boundaries.
- i_start arriving in the same cycle as o_done is ignored. A new start is accepted in IDLE only.
- o_valid deasserts in the cycle after the final handshake unless another entry is pending.

Optional Feature:
- Macro: FFT_TWIDDLE_INVERSE_EN.
- Defined: adds input port i_inverse (1 bit), sampled on the accepted i_start and held for the whole sequence. When it is 1, the im sign is flipped (W_N^−k, for IFFT). re and the sequence order are unchanged.
- Undefined: port absent; forward twiddles only.

Test Plan:
- N=16, i_ready=1, pulse i_start → 32 handshakes, each in consecutive cycles.
  - First o_valid 2 cycles after start.
  - o_done pulses once, 1 cycle after the last handshake.
- N=16, stage 0 → 8 outputs all (32767, 0), k=0.
- Stage 2 → k sequence 0,2,4,6,0,2,4,6 with twiddles (32767,0), (23170,−23170), (0,−32767), (−23170,−23170), repeating.
- Stage 3 → k=0..7; check k=4 gives (0,−32767) and k=7 gives (−30274,−12540).
- Random i_ready toggling (50%) → outputs stable while stalled; same 32-entry sequence as the ready=1 run; o_busy=1 throughout.
- Assert i_rst_n=0 after 10 handshakes, then release and restart:
  - All outputs return to 0 immediately; no o_done.
  - The restarted sequence begins at s=0, k=0.
- With FFT_TWIDDLE_INVERSE_EN and i_inverse=1: stage 3, k=2 → (23170, +23170).
- i_start pulsed again while busy → sequence unaffected; exactly 32 handshakes and one o_done.

Source files
------------

// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 DIT twiddle stream W_N^k in Q1.15 {re, im}, quarter-wave cosine ROM with folding.
// Define FFT_TWIDDLE_INVERSE_EN to add i_inverse (conjugate twiddles for the IFFT).
module fft_twiddle_sequencer #(
   parameter int unsigned N = 256,
   parameter int unsigned F = 15
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_start,
   input  logic                         i_ready,
`ifdef FFT_TWIDDLE_INVERSE_EN
   input  logic                         i_inverse,
`endif
   output logic                         o_valid,
   output logic signed [0:1][15:0]      o_twiddle,
   output logic [$clog2($clog2(N))-1:0] o_stage,
   output logic [$clog2(N)-2:0]         o_k,
   output logic                         o_busy,
   output logic                         o_done
);

   localparam int unsigned LogN    = $clog2(N);
   localparam int unsigned SW      = $clog2(LogN);
   localparam int unsigned KW      = LogN - 1;
   localparam int unsigned AW      = $clog2(N / 4 + 1);
   localparam int unsigned Quarter = N / 4;
   localparam logic [KW:0] HalfX   = {1'b1, {KW{1'b0}}};
   localparam longint      PiQ30   = 64'sd3373259426;

   // Integer Taylor series (Q30) so the table is fixed at elaboration without real math.
   function automatic logic signed [15:0] cos_q(input int unsigned m);
      longint x, x2, term, sum, res;
      if (m > Quarter) return '0;
      x    = (longint'(2) * PiQ30 * longint'(m)) / longint'(N);
      x2   = (x * x) >>> 30;
      term = longint'(1) << 30;
      sum  = term;
      for (int n = 1; n < 12; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
         sum  = sum + term;
      end
      res = (sum * (longint'(1) << F) + (longint'(1) << 29)) >>> 30;
      if (res > 32767) res = 32767;
      if (res < 0) res = 0;
      return 16'(res);
   endfunction

   logic signed [15:0] w_rom [2**AW];
   for (genvar m = 0; m < 2**AW; m++) begin : g_rom
      localparam logic signed [15:0] Val = cos_q(m);
      assign w_rom[m] = Val;
   end

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   state_t             r_state, w_state_d;
   logic [SW-1:0]      r_stage;
   logic [KW-1:0]      r_j;
   logic               r_p0_valid, r_p0_neg_re;
   logic [AW-1:0]      r_p0_addr_re, r_p0_addr_im;
   logic [SW-1:0]      r_p0_stage;
   logic [KW-1:0]      r_p0_k;
   logic               r_valid;
   logic signed [15:0] r_re, r_im;
   logic [SW-1:0]      r_stage_o;
   logic [KW-1:0]      r_k_o;

   logic               w_adv, w_issue, w_last, w_final_hs, w_neg_re, w_im_pos;
   logic [KW-1:0]      w_mask, w_shamt, w_k;
   logic [KW:0]        w_kx;
   logic [AW-1:0]      w_addr_re, w_addr_im;
   logic signed [15:0] w_rd_re, w_rd_im, w_re, w_im;

`ifdef FFT_TWIDDLE_INVERSE_EN
   logic r_inv;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_inv <= 1'b0;
      else if (r_state == StIdle && i_start) r_inv <= i_inverse;
   end
   assign w_im_pos = r_inv;
`else
   assign w_im_pos = 1'b0;
`endif

   assign w_adv      = !r_valid || i_ready;
   assign w_issue    = (r_state == StRun) && w_adv;
   assign w_last     = (r_stage == SW'(LogN - 1)) && (r_j == '1);
   assign w_final_hs = (r_state == StDrain) && r_valid && i_ready && !r_p0_valid;

   // P0: exponent and quadrant fold into two ROM addresses.
   always_comb begin
      w_mask    = (KW'(1) << r_stage) - KW'(1);
      w_shamt   = KW'(LogN - 1) - KW'(r_stage);
      w_k       = (r_j & w_mask) << w_shamt;
      w_kx      = {1'b0, w_k};
      w_addr_re = AW'(w_k);
      w_addr_im = AW'(KW'(Quarter) - w_k);
      w_neg_re  = 1'b0;
      if (w_k > KW'(Quarter)) begin
         w_addr_re = AW'(HalfX - w_kx);
         w_addr_im = AW'(w_k - KW'(Quarter));
         w_neg_re  = 1'b1;
      end
   end

   // P1: ROM read and sign application.
   always_comb begin
      w_rd_re = w_rom[r_p0_addr_re];
      w_rd_im = w_rom[r_p0_addr_im];
      w_re    = r_p0_neg_re ? -w_rd_re : w_rd_re;
      w_im    = w_im_pos ? w_rd_im : -w_rd_im;
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:  if (i_start) w_state_d = StRun;
         StRun:   if (w_issue && w_last) w_state_d = StDrain;
         StDrain: if (w_final_hs) w_state_d = StDone;
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= StIdle;
         r_stage      <= '0;
         r_j          <= '0;
         r_p0_valid   <= 1'b0;
         r_p0_neg_re  <= 1'b0;
         r_p0_addr_re <= '0;
         r_p0_addr_im <= '0;
         r_p0_stage   <= '0;
         r_p0_k       <= '0;
         r_valid      <= 1'b0;
         r_re         <= '0;
         r_im         <= '0;
         r_stage_o    <= '0;
         r_k_o        <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_issue) begin
            if (r_j == '1) begin
               r_j     <= '0;
               r_stage <= w_last ? '0 : r_stage + 1'b1;
            end else begin
               r_j <= r_j + 1'b1;
            end
         end
         if (w_adv) begin
            r_p0_valid <= w_issue;
            if (w_issue) begin
               r_p0_addr_re <= w_addr_re;
               r_p0_addr_im <= w_addr_im;
               r_p0_neg_re  <= w_neg_re;
               r_p0_stage   <= r_stage;
               r_p0_k       <= w_k;
            end
            r_valid <= r_p0_valid;
            if (r_p0_valid) begin
               r_re      <= w_re;
               r_im      <= w_im;
               r_stage_o <= r_p0_stage;
               r_k_o     <= r_p0_k;
            end
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_twiddle = {r_re, r_im};
   assign o_stage   = r_stage_o;
   assign o_k       = r_k_o;
   assign o_busy    = (r_state == StRun) || (r_state == StDrain);
   assign o_done    = (r_state == StDone);

endmodule
